// File: rtl/dl_ram_arbiter_pkg.sv
// Shared types and defaults for the download/CPU RAM arbiter.
// Optional feature macro: DL_CHECKSUM_EN (adds the dl_sum output on the top).
package dl_ram_arbiter_pkg;

  localparam int DEFAULT_AW        = 25;
  localparam int DEFAULT_FIFO_LOG2 = 2;
  localparam int DEFAULT_RAM_LAT   = 2;

  // Who currently owns the RAM port.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU_ACC = 2'd1,
    ST_DL_ACC  = 2'd2
  } arb_state_e;

  // One queued download byte at the default address width.
  typedef struct packed {
    logic [DEFAULT_AW-1:0] addr;
    logic [7:0]            data;
  } dl_entry_t;

  // Width of a counter that must reach lat-1 (never narrower than one bit).
  function automatic int ctr_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/dl_wr_fifo.sv
// Small synchronous FIFO holding download bytes while the RAM is busy.
// Pushes into a full FIFO and pops from an empty one are ignored.
module dl_wr_fifo #(
  parameter int DW   = 33,
  parameter int LOG2 = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [DW-1:0]   din,
  output logic [DW-1:0]   dout,
  output logic            full,
  output logic            empty,
  output logic [LOG2:0]   count
);

  localparam int DEPTH = 1 << LOG2;

  logic [DW-1:0]   mem_q [DEPTH];
  logic [LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2:0]   count_q, count_d;
  logic            do_push, do_pop;

  // The count can only reach DEPTH, so its top bit alone flags full.
  assign full    = count_q[LOG2];
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + {{LOG2{1'b0}}, do_push} - {{LOG2{1'b0}}, do_pop};
  end

  // Control state flops; reset flushes the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: slots are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/dl_ram_arbiter.sv
// Arbitrates the single external RAM port between the CPU requester and the
// SPI download write stream, with a small FIFO absorbing download bytes.
// Optional feature macro: DL_CHECKSUM_EN adds dl_sum, a 16-bit running sum of
// every download byte written to RAM since downloading last rose.
module dl_ram_arbiter
  import dl_ram_arbiter_pkg::*;
#(
  parameter int AW        = DEFAULT_AW,
  parameter int FIFO_LOG2 = DEFAULT_FIFO_LOG2,
  parameter int RAM_LAT   = DEFAULT_RAM_LAT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clkref,
  input  logic          downloading,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ack,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  input  logic [7:0]    ram_dout,
  output logic          ram_we,
  output logic          ram_oe,
  output logic          dl_done,
  output logic          dl_overflow
`ifdef DL_CHECKSUM_EN
  ,
  output logic [15:0]   dl_sum
`endif
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int EW    = AW + 8;
  localparam int CW    = ctr_width(RAM_LAT);
  localparam logic [CW-1:0]      LAST_CNT     = CW'(RAM_LAT - 1);
  localparam logic [FIFO_LOG2:0] DL_FIRST_LVL = (FIFO_LOG2 + 1)'(DEPTH - 1);

  // ---------------------------------------------------------------- FIFO
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FIFO_LOG2:0]   fifo_count;
  logic [EW-1:0]        fifo_head;
  logic [AW-1:0]        head_addr;
  logic [7:0]           head_data;

  assign {head_addr, head_data} = fifo_head;

  dl_wr_fifo #(
    .DW   (EW),
    .LOG2 (FIFO_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (dl_wr),
    .pop   (fifo_pop),
    .din   ({dl_addr, dl_data}),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ----------------------------------------------------------------- FSM
  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]    ram_din_q, ram_din_d;
  logic          ram_we_q, ram_we_d;
  logic          ram_oe_q, ram_oe_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d;
  logic          start_dl, start_cpu;

  // Arbitration and access sequencing; RAM signals are registered so an
  // accepted request drives the RAM on the following cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = ram_we_q;
    ram_oe_d   = ram_oe_q;
    cpu_ack_d  = 1'b0;
    cpu_dout_d = cpu_dout_q;
    fifo_pop   = 1'b0;
    start_dl   = 1'b0;
    start_cpu  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clkref) begin
          // A nearly full FIFO beats the CPU so download bytes are not lost.
          // The ack cycle still sees cpu_req high, so it must not re-accept.
          if (fifo_count >= DL_FIRST_LVL) begin
            start_dl = 1'b1;
          end else if (cpu_req && !cpu_ack_q) begin
            start_cpu = 1'b1;
          end else if (!fifo_empty) begin
            start_dl = 1'b1;
          end
        end
        if (start_dl) begin
          state_d    = ST_DL_ACC;
          cnt_d      = '0;
          fifo_pop   = 1'b1;
          ram_addr_d = head_addr;
          ram_din_d  = head_data;
          ram_we_d   = 1'b1;
          ram_oe_d   = 1'b0;
        end else if (start_cpu) begin
          state_d    = ST_CPU_ACC;
          cnt_d      = '0;
          ram_addr_d = cpu_addr;
          ram_din_d  = cpu_din;
          ram_we_d   = cpu_we;
          ram_oe_d   = !cpu_we;
        end
      end
      ST_CPU_ACC, ST_DL_ACC: begin
        if (cnt_q == LAST_CNT) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          ram_addr_d = '0;
          ram_din_d  = '0;
          ram_we_d   = 1'b0;
          ram_oe_d   = 1'b0;
          if (state_q == ST_CPU_ACC) begin
            cpu_ack_d = 1'b1;
            if (!ram_we_q) begin
              cpu_dout_d = ram_dout;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and its registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      ram_oe_q   <= 1'b0;
      cpu_ack_q  <= 1'b0;
      cpu_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      ram_oe_q   <= ram_oe_d;
      cpu_ack_q  <= cpu_ack_d;
      cpu_dout_q <= cpu_dout_d;
    end
  end

  // ------------------------------------------------------ download status
  logic dl_prev_q, dl_prev_d;
  logic done_pend_q, done_pend_d;
  logic dl_done_q, dl_done_d;
  logic dl_ovf_q, dl_ovf_d;
  logic dl_rise, dl_fall;

  assign dl_rise = downloading && !dl_prev_q;
  assign dl_fall = !downloading && dl_prev_q;

  // Completion waits for the FIFO to drain and the last byte to be written;
  // overflow stays set until the next download starts.
  always_comb begin
    dl_prev_d   = downloading;
    dl_done_d   = done_pend_q && fifo_empty && (state_q != ST_DL_ACC);
    done_pend_d = !dl_rise && ((done_pend_q && !dl_done_d) || dl_fall);
    dl_ovf_d    = (dl_ovf_q && !dl_rise) || (dl_wr && fifo_full);
  end

  // Download status flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_prev_q   <= 1'b0;
      done_pend_q <= 1'b0;
      dl_done_q   <= 1'b0;
      dl_ovf_q    <= 1'b0;
    end else begin
      dl_prev_q   <= dl_prev_d;
      done_pend_q <= done_pend_d;
      dl_done_q   <= dl_done_d;
      dl_ovf_q    <= dl_ovf_d;
    end
  end

`ifdef DL_CHECKSUM_EN
  logic [15:0] dl_sum_q, dl_sum_d;

  // Bytes are summed as they are popped into a RAM write, so the total is
  // final before dl_done can pulse.
  always_comb begin
    dl_sum_d = dl_sum_q;
    if (dl_rise) begin
      dl_sum_d = '0;
    end else if (fifo_pop) begin
      dl_sum_d = dl_sum_q + 16'(head_data);
    end
  end

  // Checksum register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_sum_q <= '0;
    end else begin
      dl_sum_q <= dl_sum_d;
    end
  end

  assign dl_sum = dl_sum_q;
`endif

  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  assign ram_we      = ram_we_q;
  assign ram_oe      = ram_oe_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_dout    = cpu_dout_q;
  assign dl_done     = dl_done_q;
  assign dl_overflow = dl_ovf_q;

endmodule
